// File: rtl/parity_pkg.sv
// rtl/parity_pkg.sv - shared types, defaults and parity helper for the odd-parity path
package parity_pkg;

   typedef enum logic {
      SHIFT  = 1'b0,
      PARITY = 1'b1
   } state_t;

   localparam int DEFAULT_DATA_W = 4;
   localparam int DEFAULT_CNT_W  = 8;

   // Zero-extending a narrower word into 'word' leaves its XOR unchanged.
   function automatic logic odd_parity_ok(input logic [31:0] word, input logic par);
      return ^{word, par};
   endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter
   import parity_pkg::*;
#(
   parameter int W = DEFAULT_CNT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] count
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (clr) begin
         r_count <= '0;
      end else if (inc && (r_count != {W{1'b1}})) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign count = r_count;

endmodule

// File: rtl/odd_parity_checker.sv
// rtl/odd_parity_checker.sv - serial odd-parity frame receiver with saturating bad-frame count
module odd_parity_checker
   import parity_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int CNT_W  = DEFAULT_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              bit_in,
   input  logic              bit_valid,
   input  logic              sync,
   output logic [DATA_W-1:0] data_out,
   output logic              frame_valid,
   output logic              parity_err,
   output logic [CNT_W-1:0]  err_count
);

   localparam int BC_W = $clog2(DATA_W + 1);
   localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W - 1);

   state_t            r_state;
   logic [BC_W-1:0]   r_bit_cnt;
   logic [DATA_W-1:0] r_shift;
   logic              r_xor;
   logic [DATA_W-1:0] r_data_out;
   logic              r_frame_valid;
   logic              r_parity_err;

   logic w_frame_ok;
   logic w_parity_cycle;
   logic w_err_inc;

   assign w_frame_ok     = odd_parity_ok(32'(r_xor), bit_in);
   assign w_parity_cycle = bit_valid && !sync && (r_state == PARITY);
   assign w_err_inc      = w_parity_cycle && !w_frame_ok;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= SHIFT;
         r_bit_cnt     <= '0;
         r_shift       <= '0;
         r_xor         <= 1'b0;
         r_data_out    <= '0;
         r_frame_valid <= 1'b0;
         r_parity_err  <= 1'b0;
      end else begin
         r_frame_valid <= 1'b0;
         // sync restarts framing but keeps the last delivered word visible
         if (sync) begin
            r_state   <= SHIFT;
            r_bit_cnt <= '0;
            r_xor     <= 1'b0;
         end else if (bit_valid) begin
            case (r_state)
               SHIFT: begin
                  r_shift <= {r_shift[DATA_W-2:0], bit_in};
                  r_xor   <= r_xor ^ bit_in;
                  if (r_bit_cnt == LAST_BIT) begin
                     r_state   <= PARITY;
                     r_bit_cnt <= '0;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                  end
               end
               PARITY: begin
                  r_data_out    <= r_shift;
                  r_parity_err  <= !w_frame_ok;
                  r_frame_valid <= 1'b1;
                  r_state       <= SHIFT;
                  r_bit_cnt     <= '0;
                  r_xor         <= 1'b0;
               end
               default: begin
                  r_state   <= SHIFT;
                  r_bit_cnt <= '0;
                  r_xor     <= 1'b0;
               end
            endcase
         end
      end
   end

   sat_counter #(
      .W (CNT_W)
   ) u_err_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (w_err_inc),
      .clr   (1'b0),
      .count (err_count)
   );

   assign data_out    = r_data_out;
   assign frame_valid = r_frame_valid;
   assign parity_err  = r_parity_err;

endmodule
